depunct_pattern: RTL

- Programmable-pattern depuncturer placed between the soft-demapper output and the Viterbi branch-metric unit.
- Turns a serial stream of DWIDTH-bit soft symbols into (A,B) code-bit pairs, inserting ERASE at punctured positions.
- Puncture pattern and period are run-time registers, so any rate up to period PMAX is supported (1/2, 2/3, 3/4, 5/6, 7/8, ...).
- Adds valid/ready backpressure on both sides, frame resync and config-load handling.

---
 rtl/depunct_pattern_if.sv | 37 +++
 rtl/depunct_pattern.sv | 125 ++++++++++++
 2 files changed

// File: rtl/depunct_pattern_if.sv
// rtl/depunct_pattern_if.sv - Bus bundle for the programmable depuncturer.
// Ports (grouped here, clock/reset stay plain on the module):
//   cfg_load/cfg_pat_a/cfg_pat_b/cfg_period_m1 : pattern configuration
//   in_data/in_valid/in_sop/in_ready           : soft-symbol input stream
//   vitin0/vitin1/vitin_valid/vitin_ready      : (A,B) pair output stream
//   sync_err                                   : partial pair dropped on resync
interface depunct_pattern_if #(
    parameter int DWIDTH = 8,
    parameter int PMAX   = 8,
    parameter int PW     = (PMAX > 1) ? $clog2(PMAX) : 1
);
    logic              cfg_load;
    logic [PMAX-1:0]   cfg_pat_a;
    logic [PMAX-1:0]   cfg_pat_b;
    logic [PW-1:0]     cfg_period_m1;
    logic [DWIDTH-1:0] in_data;
    logic              in_valid;
    logic              in_sop;
    logic              in_ready;
    logic [DWIDTH-1:0] vitin0;
    logic [DWIDTH-1:0] vitin1;
    logic              vitin_valid;
    logic              vitin_ready;
    logic              sync_err;

    modport master (
        output cfg_load, cfg_pat_a, cfg_pat_b, cfg_period_m1,
        output in_data, in_valid, in_sop, vitin_ready,
        input  in_ready, vitin0, vitin1, vitin_valid, sync_err
    );

    modport slave (
        input  cfg_load, cfg_pat_a, cfg_pat_b, cfg_period_m1,
        input  in_data, in_valid, in_sop, vitin_ready,
        output in_ready, vitin0, vitin1, vitin_valid, sync_err
    );
endinterface

// File: rtl/depunct_pattern.sv
// rtl/depunct_pattern.sv - Programmable-pattern depuncturer feeding the Viterbi branch-metric unit.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : depunct_pattern_if.slave (config, symbol input stream, pair output stream, sync_err)
module depunct_pattern #(
    parameter int                DWIDTH = 8,
    parameter int                PMAX   = 8,
    parameter logic [DWIDTH-1:0] ERASE  = '0,
    parameter int                PW     = (PMAX > 1) ? $clog2(PMAX) : 1
) (
    input  logic              clock,
    input  logic              reset,
    depunct_pattern_if.slave  bus
);

    localparam logic [PW-1:0] PMAX_M1 = PW'(PMAX - 1);

    // Shadow configuration
    logic [PW-1:0]     r_period_m1;
    logic [PMAX-1:0]   r_pat_a;
    logic [PMAX-1:0]   r_pat_b;

    // Pattern phase: pair index and slot (0 = A, 1 = B)
    logic [PW-1:0]     r_k;
    logic              r_slot;
    logic [DWIDTH-1:0] r_hold;

    // Output register
    logic [DWIDTH-1:0] r_out0;
    logic [DWIDTH-1:0] r_out1;
    logic              r_out_valid;
    logic              r_sync_err;

    logic              w_out_space;
    logic              w_pair_live;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_resync;
    logic              w_partial;
    logic [PW-1:0]     w_k_eff;
    logic              w_slot_eff;
    logic              w_complete;
    logic              w_empty;
    logic [PW-1:0]     w_k_next;
    logic [DWIDTH-1:0] w_pair_a;
    logic [DWIDTH-1:0] w_pair_b;
    logic [PW-1:0]     w_cfg_period;

    always_comb begin
        w_out_space = ~r_out_valid | bus.vitin_ready;
        w_pair_live = r_pat_a[r_k] | r_pat_b[r_k];
        w_in_ready  = w_out_space & ~reset & ~bus.cfg_load & w_pair_live;
        w_accept    = bus.in_valid & w_in_ready;
        w_resync    = w_accept & bus.in_sop;
        // Slot B with A transmitted means the A symbol is sitting in hold.
        w_partial   = r_slot & r_pat_a[r_k];

        // in_sop re-anchors the phase before the symbol is placed.
        w_k_eff    = w_resync ? '0 : r_k;
        w_slot_eff = w_resync ? ~r_pat_a[0] : r_slot;

        w_complete = w_accept & (w_slot_eff | ~r_pat_b[w_k_eff]);
        // A fully punctured pair is emitted without consuming input.
        w_empty    = w_out_space & ~bus.cfg_load & ~w_pair_live;

        w_k_next = (w_k_eff == r_period_m1) ? '0 : w_k_eff + PW'(1);

        w_pair_a = w_slot_eff ? (r_pat_a[w_k_eff] ? r_hold : ERASE) : bus.in_data;
        w_pair_b = w_slot_eff ? bus.in_data : ERASE;

        w_cfg_period = (bus.cfg_period_m1 > PMAX_M1) ? PMAX_M1 : bus.cfg_period_m1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_period_m1 <= '0;
            r_pat_a     <= PMAX'(1);
            r_pat_b     <= PMAX'(1);
            r_k         <= '0;
            r_slot      <= 1'b0;
            r_hold      <= ERASE;
            r_out0      <= ERASE;
            r_out1      <= ERASE;
            r_out_valid <= 1'b0;
            r_sync_err  <= 1'b0;
        end else begin
            if (bus.cfg_load) begin
                r_period_m1 <= w_cfg_period;
                r_pat_a     <= bus.cfg_pat_a;
                r_pat_b     <= bus.cfg_pat_b;
                r_k         <= '0;
                r_slot      <= ~bus.cfg_pat_a[0];
            end else if (w_complete || w_empty) begin
                r_k    <= w_k_next;
                r_slot <= ~r_pat_a[w_k_next];
            end else if (w_accept) begin
                r_k    <= w_k_eff;
                r_slot <= 1'b1;
                r_hold <= bus.in_data;
            end

            if (w_complete) begin
                r_out0      <= w_pair_a;
                r_out1      <= w_pair_b;
                r_out_valid <= 1'b1;
            end else if (w_empty) begin
                r_out0      <= ERASE;
                r_out1      <= ERASE;
                r_out_valid <= 1'b1;
            end else if (bus.vitin_ready) begin
                r_out_valid <= 1'b0;
            end

            r_sync_err <= w_resync & w_partial;
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.vitin0      = r_out0;
    assign bus.vitin1      = r_out1;
    assign bus.vitin_valid = r_out_valid;
    assign bus.sync_err    = r_sync_err;

endmodule
